// File: rtl/serial2parallel_if.sv
// Serial-in / word-out bus between the link deserializer and its consumer.
interface serial2parallel_if #(
    parameter int WIDTH = 4
);
    logic             din;
    logic             din_start;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             busy;
    logic             frame_err;
    logic             overflow;

    modport slave (
        input  din, din_start, dout_ready,
        output dout, dout_valid, busy, frame_err, overflow
    );

    modport master (
        output din, din_start, dout_ready,
        input  dout, dout_valid, busy, frame_err, overflow
    );
endinterface

// File: rtl/serial2parallel.sv
// MSB-first serial deserializer with restart detection and a 2-entry
// valid/ready output buffer that flags dropped words.
module serial2parallel #(
    parameter int WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    serial2parallel_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, SHIFT} state_e;

    state_e                  state_q, state_d;
    logic [WIDTH-2:0]        sr_q, sr_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    ferr_q, ferr_d;
    logic                    push;
    logic [WIDTH-1:0]        word;

    logic [1:0][WIDTH-1:0]   mem_q;
    logic                    wr_q, rd_q;
    logic [1:0]              occ_q;
    logic                    ovf_q;
    logic                    pop, push_ok;

    // sr only keeps the first WIDTH-1 bits; the last bit joins straight from din
    assign word = {sr_q, bus.din};

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        ferr_d  = 1'b0;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.din_start) begin
                    sr_d    = '0;
                    sr_d[0] = bus.din;
                    cnt_d   = CW'(1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.din_start) begin
                    ferr_d  = 1'b1;
                    sr_d    = '0;
                    sr_d[0] = bus.din;
                    cnt_d   = CW'(1);
                end else if (cnt_q == CW'(WIDTH - 1)) begin
                    push    = 1'b1;
                    sr_d    = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    sr_d  = word[WIDTH-2:0];
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            ferr_q  <= ferr_d;
        end
    end

    // A pop frees the head slot in the same cycle, so push-when-full still lands
    assign pop     = (occ_q != 2'd0) && bus.dout_ready;
    assign push_ok = push && ((occ_q != 2'd2) || pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '0;
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            occ_q <= 2'd0;
            ovf_q <= 1'b0;
        end else begin
            if (push_ok) begin
                mem_q[wr_q] <= word;
                wr_q        <= ~wr_q;
            end
            if (pop)
                rd_q <= ~rd_q;
            occ_q <= occ_q + 2'(push_ok) - 2'(pop);
            if (push && !push_ok)
                ovf_q <= 1'b1;
        end
    end

    assign bus.dout_valid = (occ_q != 2'd0);
    assign bus.dout       = (occ_q != 2'd0) ? mem_q[rd_q] : '0;
    assign bus.busy       = (state_q == SHIFT);
    assign bus.frame_err  = ferr_q;
    assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_serial2parallel.sv
// Directed bench for serial2parallel: inputs change on negedge, outputs sampled on negedge.
module tb_serial2parallel;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass = 0;
    int   n_total = 0;

    serial2parallel_if #(.WIDTH(4)) bus ();
    serial2parallel #(.WIDTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic step(input logic s, input logic d);
        @(negedge clk);
        bus.din_start = s;
        bus.din       = d;
    endtask

    task automatic send_word(input logic [3:0] w);
        for (int i = 3; i >= 0; i--)
            step(i == 3, w[i]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.din_start = 1'b0;
        bus.din = 1'b0;
        bus.dout_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.din_start = 1'b0;
        bus.din = 1'b0;
        bus.dout_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_total++;
        if ({bus.dout_valid, bus.dout, bus.busy, bus.frame_err, bus.overflow} !== 8'h00)
            $display("FAIL reset_outputs: got v=%b d=%h b=%b f=%b o=%b want all 0",
                     bus.dout_valid, bus.dout, bus.busy, bus.frame_err, bus.overflow);
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        bus.dout_ready = 1'b1;
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        n_total++;
        if (bus.busy !== 1'b1) $display("FAIL single_busy: got %b want 1", bus.busy);
        else n_pass++;
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        n_total++;
        if (bus.dout_valid !== 1'b0) $display("FAIL single_early: got valid %b want 0", bus.dout_valid);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (bus.dout_valid !== 1'b1 || bus.dout !== 4'hB)
            $display("FAIL single_word: got v=%b d=%h want v=1 d=b", bus.dout_valid, bus.dout);
        else n_pass++;
        n_total++;
        if (bus.frame_err !== 1'b0 || bus.overflow !== 1'b0 || bus.busy !== 1'b0)
            $display("FAIL single_flags: got f=%b o=%b b=%b want 0 0 0", bus.frame_err, bus.overflow, bus.busy);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (bus.dout_valid !== 1'b0 || bus.dout !== 4'h0)
            $display("FAIL single_oneshot: got v=%b d=%h want v=0 d=0", bus.dout_valid, bus.dout);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_w [4] = '{4'h5, 4'hA, 4'hF, 4'h0};
        logic [3:0] got_w [$];
        int         got_c [$];
        do_reset();
        bus.dout_ready = 1'b1;
        fork
            begin
                for (int k = 0; k < 4; k++) send_word(exp_w[k]);
                step(1'b0, 1'b0);
            end
            begin
                for (int c = 0; c < 22; c++) begin
                    @(posedge clk);
                    #1;
                    if (bus.dout_valid) begin
                        got_w.push_back(bus.dout);
                        got_c.push_back(c);
                    end
                end
            end
        join
        n_total++;
        if (got_w.size() != 4) $display("FAIL stream_count: got %0d beats want 4", got_w.size());
        else begin
            n_pass++;
            for (int k = 0; k < 4; k++) begin
                n_total++;
                if (got_w[k] !== exp_w[k]) $display("FAIL stream_word%0d: got %h want %h", k, got_w[k], exp_w[k]);
                else n_pass++;
            end
            for (int k = 1; k < 4; k++) begin
                n_total++;
                if (got_c[k] - got_c[k-1] != 4)
                    $display("FAIL stream_spacing%0d: got %0d cycles want 4", k, got_c[k] - got_c[k-1]);
                else n_pass++;
            end
        end
        n_total++;
        if (bus.overflow !== 1'b0) $display("FAIL stream_overflow: got %b want 0", bus.overflow);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        do_reset();
        send_word(4'h3);
        send_word(4'hC);
        @(negedge clk);
        n_total++;
        if (bus.dout !== 4'h3 || bus.overflow !== 1'b0)
            $display("FAIL bp_two_held: got d=%h o=%b want d=3 o=0", bus.dout, bus.overflow);
        else n_pass++;
        send_word(4'h9);
        @(negedge clk);
        n_total++;
        if (bus.dout_valid !== 1'b1 || bus.dout !== 4'h3 || bus.overflow !== 1'b1)
            $display("FAIL bp_drop: got v=%b d=%h o=%b want v=1 d=3 o=1", bus.dout_valid, bus.dout, bus.overflow);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (bus.dout !== 4'h3) $display("FAIL bp_hold: got d=%h want 3", bus.dout);
        else n_pass++;
        bus.dout_ready = 1'b1;
        @(negedge clk);
        n_total++;
        if (bus.dout_valid !== 1'b1 || bus.dout !== 4'hC || bus.overflow !== 1'b1)
            $display("FAIL bp_pop2: got v=%b d=%h o=%b want v=1 d=c o=1", bus.dout_valid, bus.dout, bus.overflow);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (bus.dout_valid !== 1'b0 || bus.overflow !== 1'b1)
            $display("FAIL bp_empty: got v=%b o=%b want v=0 o=1", bus.dout_valid, bus.overflow);
        else n_pass++;
    endtask

    task automatic test_full_push_pop();
        do_reset();
        send_word(4'h1);
        send_word(4'h2);
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        bus.dout_ready = 1'b1;
        @(negedge clk);
        n_total++;
        if (bus.dout_valid !== 1'b1 || bus.dout !== 4'h2 || bus.overflow !== 1'b0)
            $display("FAIL full_pp_head: got v=%b d=%h o=%b want v=1 d=2 o=0", bus.dout_valid, bus.dout, bus.overflow);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (bus.dout_valid !== 1'b1 || bus.dout !== 4'h7)
            $display("FAIL full_pp_next: got v=%b d=%h want v=1 d=7", bus.dout_valid, bus.dout);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (bus.dout_valid !== 1'b0 || bus.overflow !== 1'b0)
            $display("FAIL full_pp_drain: got v=%b o=%b want v=0 o=0", bus.dout_valid, bus.overflow);
        else n_pass++;
    endtask

    task automatic test_misframe();
        do_reset();
        bus.dout_ready = 1'b1;
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        n_total++;
        if (bus.frame_err !== 1'b0) $display("FAIL misframe_pre: got %b want 0", bus.frame_err);
        else n_pass++;
        step(1'b0, 1'b1);
        n_total++;
        if (bus.frame_err !== 1'b1 || bus.busy !== 1'b1)
            $display("FAIL misframe_pulse: got f=%b b=%b want f=1 b=1", bus.frame_err, bus.busy);
        else n_pass++;
        step(1'b0, 1'b1);
        n_total++;
        if (bus.frame_err !== 1'b0 || bus.dout_valid !== 1'b0)
            $display("FAIL misframe_once: got f=%b v=%b want 0 0", bus.frame_err, bus.dout_valid);
        else n_pass++;
        step(1'b0, 1'b0);
        n_total++;
        if (bus.dout_valid !== 1'b0) $display("FAIL misframe_partial: got v=%b want 0", bus.dout_valid);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (bus.dout_valid !== 1'b1 || bus.dout !== 4'h6)
            $display("FAIL misframe_word: got v=%b d=%h want v=1 d=6", bus.dout_valid, bus.dout);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (bus.dout_valid !== 1'b0) $display("FAIL misframe_extra: got v=%b want 0", bus.dout_valid);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_word(4'hA);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        @(negedge clk);
        n_total++;
        if (bus.dout_valid !== 1'b1 || bus.dout !== 4'hA || bus.busy !== 1'b1)
            $display("FAIL rstmid_pre: got v=%b d=%h b=%b want v=1 d=a b=1", bus.dout_valid, bus.dout, bus.busy);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_total++;
        if (bus.dout_valid !== 1'b0 || bus.busy !== 1'b0 || bus.dout !== 4'h0)
            $display("FAIL rstmid_async: got v=%b b=%b d=%h want 0 0 0", bus.dout_valid, bus.busy, bus.dout);
        else n_pass++;
        bus.din_start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        bus.dout_ready = 1'b1;
        send_word(4'hE);
        @(negedge clk);
        n_total++;
        if (bus.dout_valid !== 1'b1 || bus.dout !== 4'hE || bus.frame_err !== 1'b0 || bus.overflow !== 1'b0)
            $display("FAIL rstmid_next: got v=%b d=%h f=%b o=%b want v=1 d=e f=0 o=0",
                     bus.dout_valid, bus.dout, bus.frame_err, bus.overflow);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_full_push_pop();
        test_misframe();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1);
    end
endmodule
